// File: rtl/mod_exp_sm.sv
// Sequential modular exponentiator: result = base^exponent mod modulus.
// Right-to-left square-and-multiply over a bit-serial interleaved modular multiplier.
module mod_exp_sm #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             exp_ready,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] result,
  output logic             exp_done,
  output logic             busy,
  output logic             err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_REDUCE = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_MUL    = 3'd4;
  localparam logic [2:0] S_SQR    = 3'd5;
  localparam logic [2:0] S_FIN    = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] b_q, b_d, e_q, e_d, n_q, n_d, r_q, r_d;
  logic [WIDTH-1:0] acc_q, acc_d, result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d, err_q, err_d;

  // one modmul step: Acc = (2*Acc [+ Y]) mod N with two conditional subtracts
  logic [WIDTH-1:0] mm_x, mm_y, t_red1, mm_out;
  logic [WIDTH:0]   n_ext, t_dbl, t_add;
  logic             mm_bit;

  always_comb begin
    n_ext  = {1'b0, n_q};
    mm_x   = (state_q == S_MUL) ? r_q : b_q;
    mm_y   = (state_q == S_REDUCE) ? WIDTH'(1) : b_q;
    mm_bit = mm_x[cnt_q];
    t_dbl  = {acc_q, 1'b0};
    t_red1 = (t_dbl >= n_ext) ? (t_dbl[WIDTH-1:0] - n_q) : t_dbl[WIDTH-1:0];
    t_add  = {1'b0, t_red1} + (mm_bit ? {1'b0, mm_y} : '0);
    // true result is below N < 2^WIDTH, so WIDTH-bit wraparound subtract is exact
    mm_out = (t_add >= n_ext) ? (t_add[WIDTH-1:0] - n_q) : t_add[WIDTH-1:0];
  end

  always_comb begin
    state_d  = state_q;
    b_d      = b_q;
    e_d      = e_q;
    n_d      = n_q;
    r_d      = r_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = done_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (exp_ready) begin
          b_d     = base;
          e_d     = exponent;
          n_d     = modulus;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        err_d = 1'b0;
        if (n_q == '0) begin
          err_d    = 1'b1;
          result_d = '0;
          done_d   = 1'b1;
          state_d  = S_FIN;
        end else begin
          r_d     = (n_q == WIDTH'(1)) ? '0 : WIDTH'(1);
          acc_d   = '0;
          cnt_d   = CW'(WIDTH - 1);
          state_d = S_REDUCE;
        end
      end
      S_REDUCE: begin
        acc_d = mm_out;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          b_d     = mm_out;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        acc_d = '0;
        cnt_d = CW'(WIDTH - 1);
        if (e_q == '0) begin
          result_d = r_q;
          done_d   = 1'b1;
          state_d  = S_FIN;
        end else begin
          state_d = e_q[0] ? S_MUL : S_SQR;
        end
      end
      S_MUL: begin
        acc_d = mm_out;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          r_d     = mm_out;
          acc_d   = '0;
          cnt_d   = CW'(WIDTH - 1);
          state_d = S_SQR;
        end
      end
      S_SQR: begin
        acc_d = mm_out;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          b_d     = mm_out;
          e_d     = e_q >> 1;
          state_d = S_CHECK;
        end
      end
      S_FIN: begin
        if (!exp_ready) begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      b_q      <= '0;
      e_q      <= '0;
      n_q      <= '0;
      r_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      b_q      <= b_d;
      e_q      <= e_d;
      n_q      <= n_d;
      r_q      <= r_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign result   = result_q;
  assign exp_done = done_q;
  assign err      = err_q;
  assign busy     = (state_q != S_IDLE) && (state_q != S_FIN);

endmodule

// File: tb/tb_mod_exp_sm.sv
// Directed bench for mod_exp_sm: hand-computed results, latencies and handshake behaviour.
module tb_mod_exp_sm;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        exp_ready = 1'b0;
  logic [31:0] base = '0, exponent = '0, modulus = '0;
  logic [31:0] result;
  logic        exp_done, busy, err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mod_exp_sm #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .exp_ready (exp_ready),
    .base      (base),
    .exponent  (exponent),
    .modulus   (modulus),
    .result    (result),
    .exp_done  (exp_done),
    .busy      (busy),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%08h) want %0d (0x%08h)", tag, got, got, want, want);
    end
  endtask

  // drop_at != 0 releases exp_ready right after that edge, before completion
  task automatic run(input string tag, input logic [31:0] b, input logic [31:0] e,
                     input logic [31:0] m, input logic [31:0] want, input logic want_err,
                     input int want_lat, input int drop_at);
    int  edges;
    bit  seen;
    @(negedge clk);
    base = b; exponent = e; modulus = m; exp_ready = 1'b1;
    edges = 0; seen = 0;
    while (!seen && edges < 2000) begin
      @(posedge clk); edges++; #1;
      if (edges == 1) chk({tag, ".busy_run"}, {31'b0, busy}, 32'd1);
      if (drop_at != 0 && edges == drop_at) exp_ready = 1'b0;
      if (exp_done) seen = 1;
    end
    chk({tag, ".done_seen"}, {31'b0, seen}, 32'd1);
    chk({tag, ".latency"}, edges, want_lat);
    chk({tag, ".result"}, result, want);
    chk({tag, ".err"}, {31'b0, err}, {31'b0, want_err});
    chk({tag, ".busy_fin"}, {31'b0, busy}, 32'd0);
    if (exp_ready) begin
      repeat (3) @(posedge clk);
      #1 chk({tag, ".done_hold"}, {31'b0, exp_done}, 32'd1);
      exp_ready = 1'b0;
    end
    @(posedge clk); #1;
    chk({tag, ".done_clr"}, {31'b0, exp_done}, 32'd0);
    chk({tag, ".result_hold"}, result, want);
  endtask

  initial begin
    #12;
    chk("reset.result", result, 32'd0);
    chk("reset.done", {31'b0, exp_done}, 32'd0);
    chk("reset.busy", {31'b0, busy}, 32'd0);
    chk("reset.err", {31'b0, err}, 32'd0);
    @(negedge clk); reset_n = 1'b1;

    run("t1", 32'd4, 32'd13, 32'd497, 32'd445, 1'b0, 263, 0);
    run("rsa_enc", 32'd65, 32'd17, 32'd3233, 32'd2790, 1'b0, 264, 0);
    run("rsa_dec", 32'd2790, 32'd2753, 32'd3233, 32'd65, 1'b0, 591, 0);
    run("breduce", 32'd1000, 32'd1, 32'd7, 32'd6, 1'b0, 100, 0);
    run("carry", 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFB, 32'd16, 1'b0, 133, 0);
    run("exp0", 32'd5, 32'd0, 32'd7, 32'd1, 1'b0, 35, 0);
    run("mod1", 32'd5, 32'd3, 32'd1, 32'd0, 1'b0, 165, 0);
    run("mod0", 32'd5, 32'd3, 32'd0, 32'd0, 1'b1, 2, 0);
    run("errclr", 32'd3, 32'd2, 32'd5, 32'd4, 1'b0, 133, 0);
    run("drop", 32'd4, 32'd13, 32'd497, 32'd445, 1'b0, 263, 50);

    // reset pulse during the SQR following the first MUL (edges 68..99)
    @(negedge clk);
    base = 32'd4; exponent = 32'd13; modulus = 32'd497; exp_ready = 1'b1;
    repeat (80) @(posedge clk);
    #1 reset_n = 1'b0; exp_ready = 1'b0;
    #1;
    chk("rst_mid.result", result, 32'd0);
    chk("rst_mid.done", {31'b0, exp_done}, 32'd0);
    chk("rst_mid.busy", {31'b0, busy}, 32'd0);
    chk("rst_mid.err", {31'b0, err}, 32'd0);
    @(negedge clk); reset_n = 1'b1;
    run("after_rst", 32'd4, 32'd13, 32'd497, 32'd445, 1'b0, 263, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
